alu_operand_sequencer: RTL and testbench

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

---
 rtl/alu_operand_sequencer_if.sv | 14 +
 rtl/alu_operand_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_operand_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_if.sv
// ALU-facing bus of the operand sequencer: registered operands/op out,
// combinational result and invalid flag back from the ALU.
interface alu_operand_sequencer_if #(
  parameter int bits = 8
);
  logic [bits-1:0] A;
  logic [bits-1:0] B;
  logic [1:0]      op;
  logic [bits:0]   res_in;
  logic            invalido_in;

  modport master (output A, output B, output op, input res_in, input invalido_in);
  modport slave  (input A, input B, input op, output res_in, output invalido_in);
endinterface

// File: rtl/alu_operand_sequencer.sv
// Switch-driven operand sequencer: collects A, B and op with enter/undo pulses,
// captures the ALU result one cycle later and supports result chaining.
module alu_operand_sequencer #(
  parameter int bits = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [bits-1:0]         data_in,
  input  logic [1:0]              op_in,
  input  logic                    enter,
  input  logic                    undo,
  alu_operand_sequencer_if.master alu,
  output logic [bits:0]           result,
  output logic                    invalid,
  output logic                    result_valid,
  output logic [2:0]              state,
  output logic [bits:0]           display_val
);

  localparam logic [2:0] ST_ENTER_A  = 3'd0;
  localparam logic [2:0] ST_ENTER_B  = 3'd1;
  localparam logic [2:0] ST_ENTER_OP = 3'd2;
  localparam logic [2:0] ST_EXEC     = 3'd3;
  localparam logic [2:0] ST_SHOW     = 3'd4;

  logic [2:0]      state_r;
  logic [2:0]      next_state_s;
  logic [bits-1:0] a_r;
  logic [bits-1:0] b_r;
  logic [1:0]      op_r;
  logic [bits:0]   result_r;
  logic            invalid_r;
  logic            valid_r;
  logic            accept_s;
  logic            clear_s;
  logic [bits:0]   display_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_ENTER_A;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; undo wins over enter, EXEC ignores both
  always_comb begin
    next_state_s = ST_ENTER_A;
    case (state_r)
      ST_ENTER_A: begin
        if (enter && !undo) next_state_s = ST_ENTER_B;
        else                next_state_s = ST_ENTER_A;
      end
      ST_ENTER_B: begin
        if (undo)       next_state_s = ST_ENTER_A;
        else if (enter) next_state_s = ST_ENTER_OP;
        else            next_state_s = ST_ENTER_B;
      end
      ST_ENTER_OP: begin
        if (undo)       next_state_s = ST_ENTER_B;
        else if (enter) next_state_s = ST_EXEC;
        else            next_state_s = ST_ENTER_OP;
      end
      ST_EXEC: next_state_s = ST_SHOW;
      ST_SHOW: begin
        if (undo)                    next_state_s = ST_ENTER_A;
        else if (enter && invalid_r) next_state_s = ST_ENTER_A;
        else if (enter)              next_state_s = ST_ENTER_B;
        else                         next_state_s = ST_SHOW;
      end
      default: next_state_s = ST_ENTER_A;
    endcase
  end

  // Output/control decode: wipe conditions and the display mux
  always_comb begin
    accept_s  = enter && !undo;
    clear_s   = 1'b0;
    display_s = {(bits+1){1'b0}};
    case (state_r)
      ST_ENTER_A, ST_ENTER_B: display_s = {1'b0, data_in};
      ST_ENTER_OP, ST_EXEC:   display_s = {1'b0, b_r};
      ST_SHOW: begin
        display_s = result_r;
        clear_s   = undo || (enter && invalid_r);
      end
      default: clear_s = 1'b1;
    endcase
  end

  // Operand, op and result capture registers
  always_ff @(posedge clk) begin
    if (reset || clear_s) begin
      a_r       <= {bits{1'b0}};
      b_r       <= {bits{1'b0}};
      op_r      <= 2'b00;
      result_r  <= {(bits+1){1'b0}};
      invalid_r <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_ENTER_A:  if (accept_s) a_r <= data_in;
        ST_ENTER_B:  if (accept_s) b_r <= data_in;
        ST_ENTER_OP: if (accept_s) op_r <= op_in;
        ST_EXEC: begin
          // op_r settled on the previous edge, so res_in is stable here
          result_r  <= alu.res_in;
          invalid_r <= alu.invalido_in;
          valid_r   <= 1'b1;
        end
        ST_SHOW: begin
          if (accept_s) begin
            a_r     <= result_r[bits-1:0];
            valid_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign alu.A        = a_r;
  assign alu.B        = b_r;
  assign alu.op       = op_r;
  assign result       = result_r;
  assign invalid      = invalid_r;
  assign result_valid = valid_r;
  assign state        = state_r;
  assign display_val  = display_s;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed enter/undo/reset sequences, a
// transaction-level reference model compared every cycle, plus literal pins.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic [1:0] op_in = 2'd0;
  logic       enter = 1'b0;
  logic       undo = 1'b0;
  logic [8:0] result;
  logic       invalid;
  logic       result_valid;
  logic [2:0] state;
  logic [8:0] display_val;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  // reference model: phase, operands and captured result
  int         m_state;
  logic [7:0] m_a, m_b;
  logic [1:0] m_op;
  logic [8:0] m_res;
  logic       m_inv, m_rv;

  alu_operand_sequencer_if #(.bits(8)) bus ();

  alu_operand_sequencer #(.bits(8)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .op_in(op_in),
    .enter(enter), .undo(undo), .alu(bus.master),
    .result(result), .invalid(invalid), .result_valid(result_valid),
    .state(state), .display_val(display_val)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_res(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
    int r;
    case (o)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b);
      2'd2:    r = int'(a & b);
      default: r = int'(a | b);
    endcase
    return r[8:0];
  endfunction

  function automatic logic alu_inv(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
    if (o == 2'd0) return (int'(a) + int'(b)) > 255;
    else if (o == 2'd1) return int'(a) < int'(b);
    else return 1'b0;
  endfunction

  // model ALU attached to the sequencer's operand bus
  always_comb begin
    bus.res_in      = alu_res(bus.A, bus.B, bus.op);
    bus.invalido_in = alu_inv(bus.A, bus.B, bus.op);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_clear();
    m_state = 0; m_a = 8'd0; m_b = 8'd0; m_op = 2'd0;
    m_res = 9'd0; m_inv = 1'b0; m_rv = 1'b0;
  endtask

  // one clock with the given inputs; model advances after the edge
  task automatic cycle(input logic r, input logic e, input logic u,
                       input logic [7:0] d, input logic [1:0] o);
    reset = r; enter = e; undo = u; data_in = d; op_in = o;
    @(posedge clk);
    #1;
    if (r) m_clear();
    else begin
      case (m_state)
        0: if (e && !u) begin m_a = d; m_state = 1; end
        1: if (u) m_state = 0;
           else if (e) begin m_b = d; m_state = 2; end
        2: if (u) m_state = 1;
           else if (e) begin m_op = o; m_state = 3; end
        3: begin
          m_res = alu_res(m_a, m_b, m_op);
          m_inv = alu_inv(m_a, m_b, m_op);
          m_rv = 1'b1;
          m_state = 4;
        end
        default: if (u || (e && m_inv)) m_clear();
                 else if (e) begin m_a = m_res[7:0]; m_rv = 1'b0; m_state = 1; end
      endcase
    end
    started = 1'b1;
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      logic [8:0] exp_disp;
      if (m_state <= 1) exp_disp = {1'b0, data_in};
      else if (m_state <= 3) exp_disp = {1'b0, m_b};
      else exp_disp = m_res;
      chk("state", 32'(state), 32'(m_state));
      chk("A", 32'(bus.A), 32'(m_a));
      chk("B", 32'(bus.B), 32'(m_b));
      chk("op", 32'(bus.op), 32'(m_op));
      chk("result", 32'(result), 32'(m_res));
      chk("invalid", 32'(invalid), 32'(m_inv));
      chk("result_valid", 32'(result_valid), 32'(m_rv));
      chk("display_val", 32'(display_val), 32'(exp_disp));
    end
  end

  initial begin
    m_clear();
    cycle(1'b1, 1'b1, 1'b1, 8'h00, 2'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_rv", 32'(result_valid), 32'd0);

    // add overflow 200+100
    cycle(1'b0, 1'b1, 1'b0, 8'd200, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd100, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    chk("add_state", 32'(state), 32'd4);
    chk("add_result", 32'(result), 32'h12C);
    chk("add_invalid", 32'(invalid), 32'd1);
    chk("add_display", 32'(display_val), 32'h12C);
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    chk("add_clear_state", 32'(state), 32'd0);

    // subtract underflow 5-10
    cycle(1'b0, 1'b1, 1'b0, 8'd5, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd10, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 2'd1);
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    chk("sub_result", 32'(result), 32'h1FB);
    chk("sub_invalid", 32'(invalid), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    chk("sub_clear_A", 32'(bus.A), 32'd0);
    chk("sub_clear_result", 32'(result), 32'd0);

    // chaining: F0 & 3C, then | 0F
    cycle(1'b0, 1'b1, 1'b0, 8'hF0, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h3C, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 2'd2);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    chk("and_result", 32'(result), 32'h030);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
    chk("chain_state", 32'(state), 32'd1);
    chk("chain_A", 32'(bus.A), 32'h30);
    cycle(1'b0, 1'b1, 1'b0, 8'h0F, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 2'd3);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    chk("or_result", 32'(result), 32'h03F);
    cycle(1'b0, 1'b0, 1'b1, 8'h00, 2'd0);
    chk("show_undo_state", 32'(state), 32'd0);

    // undo paths and priority
    cycle(1'b0, 1'b1, 1'b0, 8'h11, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h22, 2'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'h00, 2'd0);
    chk("undo_op_state", 32'(state), 32'd1);
    chk("undo_op_B", 32'(bus.B), 32'h22);
    cycle(1'b0, 1'b1, 1'b1, 8'h55, 2'd0);
    chk("undo_pri_state", 32'(state), 32'd0);
    chk("undo_pri_B", 32'(bus.B), 32'h22);
    cycle(1'b0, 1'b0, 1'b0, 8'h99, 2'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'h98, 2'd0);
    chk("hold_A", 32'(bus.A), 32'h11);

    // enter/undo during EXEC ignored
    cycle(1'b0, 1'b1, 1'b0, 8'd1, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd2, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    cycle(1'b0, 1'b1, 1'b1, 8'h44, 2'd1);
    chk("exec_ign_state", 32'(state), 32'd4);
    chk("exec_ign_result", 32'(result), 32'd3);
    cycle(1'b0, 1'b0, 1'b1, 8'd0, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd7, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd8, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 2'd1);
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    chk("exec_enter_result", 32'(result), 32'h1FF);
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 2'd0);

    // reset in EXEC, then enter on the first free edge
    cycle(1'b0, 1'b1, 1'b0, 8'd3, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd4, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 2'd2);
    cycle(1'b1, 1'b1, 1'b1, 8'd0, 2'd0);
    chk("rst_exec_state", 32'(state), 32'd0);
    chk("rst_exec_A", 32'(bus.A), 32'd0);
    chk("rst_exec_op", 32'(bus.op), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h77, 2'd0);
    chk("post_rst_A", 32'(bus.A), 32'h77);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 2'd0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
